column_fir_filter: RTL and testbench

Vertical (column) pass of the separable linear-phase FIR denoiser. It sits directly downstream of the row-to-column transpose stage. It drives that stage's read enable, consumes the column-major pixel stream one column of IMAGE_HEIGHT samples at a time, and applies a 5-tap symmetric FIR with edge replication at column boundaries. It emits one filtered, rounded, saturated pixel per input pixel, in column-major order.

---
 rtl/column_fir_filter.sv | 174 +++++++++++++++++
 tb/tb_column_fir_filter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/column_fir_filter.sv
// Vertical 5-tap symmetric FIR over a column-major pixel stream, with edge
// replication at the top and bottom of each column and rounded, saturated output.
module column_fir_filter #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned IMAGE_WIDTH  = 110,
  parameter int unsigned IMAGE_HEIGHT = 103,
  parameter int unsigned COEF_WIDTH   = 8,
  parameter int unsigned C0           = 1,
  parameter int unsigned C1           = 4,
  parameter int unsigned C2           = 6,
  parameter int unsigned SHIFT        = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned ACC_W = DATA_WIDTH + COEF_WIDTH + 3;
  localparam int unsigned SUM_W = DATA_WIDTH + 1;
  localparam int unsigned ROW_W = $clog2(IMAGE_HEIGHT + 1);
  localparam int unsigned COL_W = $clog2(IMAGE_WIDTH + 1);

  localparam logic [COEF_WIDTH-1:0] K0 = COEF_WIDTH'(C0);
  localparam logic [COEF_WIDTH-1:0] K1 = COEF_WIDTH'(C1);
  localparam logic [COEF_WIDTH-1:0] K2 = COEF_WIDTH'(C2);
  localparam logic [ACC_W:0]        ROUND   = (ACC_W+1)'(2 ** (SHIFT - 1));
  localparam logic [ACC_W:0]        PIX_MAX = (ACC_W+1)'(2 ** DATA_WIDTH - 1);
  localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [ROW_W-1:0]      ROW_CNT  = ROW_W'(IMAGE_HEIGHT);
  localparam logic [COL_W-1:0]      COL_LAST = COL_W'(IMAGE_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_FLUSH1, S_FLUSH2, S_DRAIN
  } state_t;

  state_t                 state;
  logic [ROW_W-1:0]       req_cnt;
  logic [ROW_W-1:0]       rx_cnt;
  logic [COL_W-1:0]       col_cnt;
  logic [DATA_WIDTH-1:0]  win   [5];
  logic [DATA_WIDTH-1:0]  win_n [5];
  logic                   accept_c;
  logic                   flush_c;
  logic                   emit_c;
  logic [SUM_W-1:0]       p_outer;
  logic [SUM_W-1:0]       p_inner;
  logic [DATA_WIDTH-1:0]  p_ctr;
  logic                   p_valid;
  logic [ACC_W-1:0]       acc_c;
  logic [ACC_W:0]         rnd_c;

  assign accept_c = valid_in && (state == S_READ || state == S_WAIT) && (rx_cnt < ROW_CNT);
  assign flush_c  = (state == S_FLUSH1) || (state == S_FLUSH2);

  // Window update: sample 0 replicates into the top taps, flush ticks replicate the last sample.
  always_comb begin
    win_n  = win;
    emit_c = 1'b0;
    if (accept_c) begin
      if (rx_cnt == ROW_W'(0)) begin
        win_n[0] = data_in;
        win_n[1] = data_in;
        win_n[2] = data_in;
      end else if (rx_cnt == ROW_W'(1)) begin
        win_n[3] = data_in;
      end else if (rx_cnt == ROW_W'(2)) begin
        win_n[4] = data_in;
        emit_c   = 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) win_n[i] = win[i+1];
        win_n[4] = data_in;
        emit_c   = 1'b1;
      end
    end else if (flush_c) begin
      for (int i = 0; i < 4; i++) win_n[i] = win[i+1];
      win_n[4] = win[4];
      emit_c   = 1'b1;
    end
  end

  always_comb begin
    acc_c = ACC_W'(K0) * ACC_W'(p_outer) + ACC_W'(K1) * ACC_W'(p_inner) + ACC_W'(K2) * ACC_W'(p_ctr);
    rnd_c = ((ACC_W+1)'(acc_c) + ROUND) >> SHIFT;
  end

  // Frame sequencing and upstream read requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      read_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      req_cnt <= '0;
      rx_cnt  <= '0;
      col_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (accept_c) rx_cnt <= rx_cnt + ROW_W'(1);
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_READ;
            read_en <= 1'b1;
            busy    <= 1'b1;
            req_cnt <= '0;
            rx_cnt  <= '0;
            col_cnt <= '0;
          end
        end
        S_READ: begin
          req_cnt <= req_cnt + ROW_W'(1);
          if (req_cnt == ROW_LAST) begin
            read_en <= 1'b0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rx_cnt == ROW_CNT || (accept_c && rx_cnt == ROW_LAST)) state <= S_FLUSH1;
        end
        S_FLUSH1: state <= S_FLUSH2;
        S_FLUSH2: begin
          rx_cnt <= '0;
          if (col_cnt == COL_LAST) begin
            state <= S_DRAIN;
          end else begin
            col_cnt <= col_cnt + COL_W'(1);
            req_cnt <= '0;
            read_en <= 1'b1;
            state   <= S_READ;
          end
        end
        S_DRAIN: begin
          if (!p_valid && !valid_out) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Window, pre-add stage and MAC/round/saturate stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) win[i] <= '0;
      p_outer   <= '0;
      p_inner   <= '0;
      p_ctr     <= '0;
      p_valid   <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      win     <= win_n;
      p_valid <= emit_c;
      if (emit_c) begin
        p_outer <= SUM_W'(win_n[0]) + SUM_W'(win_n[4]);
        p_inner <= SUM_W'(win_n[1]) + SUM_W'(win_n[3]);
        p_ctr   <= win_n[2];
      end
      valid_out <= p_valid;
      if (p_valid) data_out <= (rnd_c > PIX_MAX) ? '1 : rnd_c[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_column_fir_filter.sv
// Scoreboard bench for column_fir_filter: a model transpose stage answers read_en,
// expected pixels are queued per frame and checked by an independent monitor.
module tb_column_fir_filter;

  localparam int W = 110;
  localparam int H = 103;

  logic       clk = 1'b0;
  logic       reset, start, read_en, valid_in, valid_out, busy, done;
  logic [7:0] data_in, data_out;
  logic       start2, read_en2, valid_in2, valid_out2, busy2, done2;
  logic [7:0] data_in2, data_out2;

  always #5 clk = ~clk;

  column_fir_filter dut (
    .clk(clk), .reset(reset), .start(start), .read_en(read_en),
    .data_in(data_in), .valid_in(valid_in), .data_out(data_out),
    .valid_out(valid_out), .busy(busy), .done(done)
  );

  column_fir_filter #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(5), .SHIFT(3)) dut_sat (
    .clk(clk), .reset(reset), .start(start2), .read_en(read_en2),
    .data_in(data_in2), .valid_in(valid_in2), .data_out(data_out2),
    .valid_out(valid_out2), .busy(busy2), .done(done2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_vo  = 0;
  int n_out    = 0;
  int n_out2   = 0;
  int sb[$];
  int up_mode  = 0;
  bit up_jitter = 1'b0;
  bit stray    = 1'b0;
  int pend     = 0;
  int sent     = 0;
  bit rd2_q    = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Mode 0: flat 100. Mode 1: per-column directed patterns chosen by col%4.
  function automatic int pix(input int mode, input int c, input int r);
    if (mode == 0) return 100;
    case (c % 4)
      0:       return (r == 50)    ? 16  : 0;
      1:       return (r == 0)     ? 160 : 0;
      2:       return (r == H - 1) ? 160 : 0;
      default: return (r == 30)    ? 4   : 0;
    endcase
  endfunction

  // Hand-computed filter responses for the patterns above.
  function automatic int exp_pix(input int mode, input int c, input int r);
    if (mode == 0) return 100;
    case (c % 4)
      0: case (r)
           48: return 1;  49: return 4;  50: return 6;
           51: return 4;  52: return 1;  default: return 0;
         endcase
      1: case (r)
           0: return 110; 1: return 50; 2: return 10; default: return 0;
         endcase
      2: case (r)
           102: return 110; 101: return 50; 100: return 10; default: return 0;
         endcase
      default: case (r)
           29: return 1; 30: return 2; 31: return 1; default: return 0;
         endcase
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model transpose stage: answers each read_en one cycle later, optional bubbles.
  initial begin
    valid_in = 1'b0;
    data_in  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 0; sent = 0; valid_in = 1'b0; data_in = '0;
      end else begin
        if (stray) begin
          valid_in = 1'b1; data_in = 8'hff;
        end else if (pend > 0 && !(up_jitter && $urandom_range(2) == 0)) begin
          valid_in = 1'b1;
          data_in  = 8'(pix(up_mode, sent / H, sent % H));
          sent     = (sent == W * H - 1) ? 0 : sent + 1;
          pend--;
        end else begin
          valid_in = 1'b0;
        end
        if (read_en) pend++;
      end
    end
  end

  // Output monitor for the main DUT.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!reset && valid_out) begin
        if (sb.size() == 0) begin
          check("unexpected_valid_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check($sformatf("pixel[%0d]", n_out), int'(data_out), e);
        end
        n_out++;
        last_vo = cyc;
      end
    end
  end

  // Saturation DUT: constant 255 source and its monitor.
  initial begin
    valid_in2 = 1'b0;
    data_in2  = 8'd255;
    forever begin
      @(negedge clk);
      valid_in2 = rd2_q;
      rd2_q     = read_en2;
      if (valid_out2) begin
        check($sformatf("sat_pixel[%0d]", n_out2), int'(data_out2), 255);
        n_out2++;
      end
    end
  end

  task automatic push_frame(input int mode);
    for (int c = 0; c < W; c++)
      for (int r = 0; r < H; r++) sb.push_back(exp_pix(mode, c, r));
  endtask

  task automatic run_frame(input int mode, input bit jit, input bit poke);
    int got;
    up_mode = mode; up_jitter = jit; n_out = 0;
    push_frame(mode);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    got = 0;
    for (int i = 0; i < 40000; i++) begin
      @(negedge clk);
      start = poke && (i == 3000);
      if (done) begin got = 1; break; end
    end
    start = 1'b0;
    check("done_seen", got, 1);
    if (got == 1) check("done_latency", cyc - last_vo, 2);
    check("out_count", n_out, W * H);
    check("sb_empty", sb.size(), 0);
    @(negedge clk);
    check("done_single_pulse", int'(done), 0);
    check("busy_cleared", int'(busy), 0);
  endtask

  initial begin
    int got;
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_read_en", int'(read_en), 0);
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_data_out", int'(data_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b0;

    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    got = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done2) begin got = 1; break; end
    end
    check("sat_done_seen", got, 1);
    check("sat_count", n_out2, 20);
    @(negedge clk);
    check("sat_busy_cleared", int'(busy2), 0);

    // Stray valid_in while idle must be ignored.
    stray = 1'b1;
    repeat (3) @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    check("idle_no_output", n_out, 0);

    run_frame(1, 1'b0, 1'b0);
    run_frame(1, 1'b1, 1'b1);

    // Abort at column 5, row 40, then a full frame.
    up_mode = 0; up_jitter = 1'b0; n_out = 0;
    push_frame(0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    got = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (sent >= 5 * H + 41) begin got = 1; break; end
    end
    check("abort_point_reached", got, 1);
    check("abort_busy_before", int'(busy), 1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_read_en", int'(read_en), 0);
    check("abort_valid_out", int'(valid_out), 0);
    check("abort_data_out", int'(data_out), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    sb.delete();
    got = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || valid_out || read_en) got = 1;
    end
    check("abort_stays_idle", got, 0);

    run_frame(0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
